div_batch_sequencer: RTL and testbench

Time-multiplexes a single `division` unit (Newton-Raphson divider: `clk`, `load`, `nr`, `dr`, `initial_guess`, `division_res`) across a batch of N operand sets. It replaces N parallel dividers.

- Host loads operand triples into an internal bank, pulses `start`, waits for `done`, then reads quotients back through a registered read port.
- Drives the divider's `load` and operand inputs.
- Times the fixed iteration window and captures each result into a result buffer.

---
 rtl/div_batch_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_div_batch_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_batch_sequencer.sv
// Batch sequencer sharing one Newton-Raphson divider across N operand sets.
// Zero divisors bypass the divider and store a saturated quotient.
module div_batch_sequencer #(
  parameter int N           = 9,
  parameter int W           = 16,
  parameter int AW          = 4,
  parameter int LOAD_CYCLES = 1,
  parameter int ITER_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic signed [W-1:0] wr_nr,
  input  logic signed [W-1:0] wr_dr,
  input  logic signed [W-1:0] wr_guess,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [N-1:0]        dz_mask,
  input  logic [AW-1:0]       rd_addr,
  output logic signed [W-1:0] rd_data,
  output logic                div_load,
  output logic signed [W-1:0] div_nr,
  output logic signed [W-1:0] div_dr,
  output logic signed [W-1:0] div_guess,
  input  logic signed [W-1:0] div_res
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_CAPTURE, S_DONE
  } state_t;

  localparam logic signed [W-1:0] SAT_P =
    {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_N =
    {1'b1, {(W-2){1'b0}}, 1'b1};

  state_t state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [N-1:0] dz_q, dz_d;
  logic signed [W-1:0] dnr_q, dnr_d;
  logic signed [W-1:0] ddr_q, ddr_d;
  logic signed [W-1:0] dgs_q, dgs_d;
  logic signed [W-1:0] rd_q, rd_d;

  logic signed [W-1:0] bnr_q [N];
  logic signed [W-1:0] bdr_q [N];
  logic signed [W-1:0] bgs_q [N];
  logic signed [W-1:0] res_q [N];

  logic wr_ok, rd_in;
  logic cap_we;
  logic signed [W-1:0] cap_val;
  logic [AW-1:0] nxt;
  logic signed [W-1:0] e0_nr, e0_dr, e0_gs;

  assign wr_ok = wr_en && (state_q == S_IDLE) &&
                 ({1'b0, wr_addr} < (AW+1)'(N));
  assign rd_in = {1'b0, rd_addr} < (AW+1)'(N);
  assign nxt   = idx_q + AW'(1);

  // A write landing on the start edge must be seen by entry 0
  always_comb begin
    e0_nr = bnr_q[0];
    e0_dr = bdr_q[0];
    e0_gs = bgs_q[0];
    if (wr_ok && wr_addr == '0) begin
      e0_nr = wr_nr;
      e0_dr = wr_dr;
      e0_gs = wr_guess;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    dnr_d   = dnr_q;
    ddr_d   = ddr_q;
    dgs_d   = dgs_q;
    cap_we  = 1'b0;
    cap_val = div_res;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dz_d  = '0;
          idx_d = '0;
          cnt_d = '0;
          if (e0_dr == '0) begin
            state_d = S_CAPTURE;
          end else begin
            state_d = S_LOAD;
            dnr_d   = e0_nr;
            ddr_d   = e0_dr;
            dgs_d   = e0_gs;
          end
        end
      end
      S_LOAD: begin
        if (cnt_q == 16'(LOAD_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RUN: begin
        if (cnt_q == 16'(ITER_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_CAPTURE: begin
        cap_we = 1'b1;
        if (bdr_q[idx_q] == '0) begin
          cap_val     = (bnr_q[idx_q] >= 0) ? SAT_P : SAT_N;
          dz_d[idx_q] = 1'b1;
        end
        if (idx_q == AW'(N - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d = nxt;
          cnt_d = '0;
          if (bdr_q[nxt] == '0) begin
            state_d = S_CAPTURE;
          end else begin
            state_d = S_LOAD;
            dnr_d   = bnr_q[nxt];
            ddr_d   = bdr_q[nxt];
            dgs_d   = bgs_q[nxt];
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_d = rd_in ? res_q[rd_addr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      dz_q    <= '0;
      dnr_q   <= '0;
      ddr_q   <= '0;
      dgs_q   <= '0;
      rd_q    <= '0;
      for (int i = 0; i < N; i++) begin
        bnr_q[i] <= '0;
        bdr_q[i] <= '0;
        bgs_q[i] <= '0;
        res_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      dnr_q   <= dnr_d;
      ddr_q   <= ddr_d;
      dgs_q   <= dgs_d;
      rd_q    <= rd_d;
      if (wr_ok) begin
        bnr_q[wr_addr] <= wr_nr;
        bdr_q[wr_addr] <= wr_dr;
        bgs_q[wr_addr] <= wr_guess;
      end
      if (cap_we) res_q[idx_q] <= cap_val;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign div_load  = (state_q == S_LOAD);
  assign dz_mask   = dz_q;
  assign rd_data   = rd_q;
  assign div_nr    = dnr_q;
  assign div_dr    = ddr_q;
  assign div_guess = dgs_q;

endmodule

// File: tb/tb_div_batch_sequencer.sv
// Directed bench for div_batch_sequencer with a behavioral divider model.
module tb_div_batch_sequencer;
  localparam int N = 9;
  localparam int W = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic signed [W-1:0] wr_nr = '0, wr_dr = '0, wr_guess = '0;
  logic start = 1'b0;
  logic busy, done, div_load;
  logic [N-1:0] dz_mask;
  logic [AW-1:0] rd_addr = '0;
  logic signed [W-1:0] rd_data, div_nr, div_dr, div_guess, div_res;

  logic signed [W-1:0] m_nr = '0, m_dr = '0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (div_load) begin
    m_nr <= div_nr;
    m_dr <= div_dr;
  end
  assign div_res = (m_dr == '0) ? '0 : m_nr / m_dr;

  div_batch_sequencer dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_nr(wr_nr), .wr_dr(wr_dr), .wr_guess(wr_guess),
    .start(start), .busy(busy), .done(done), .dz_mask(dz_mask),
    .rd_addr(rd_addr), .rd_data(rd_data), .div_load(div_load),
    .div_nr(div_nr), .div_dr(div_dr), .div_guess(div_guess),
    .div_res(div_res)
  );

  task automatic wr(input int a, input int nr, input int dr);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = AW'(a);
    wr_nr = W'(nr); wr_dr = W'(dr); wr_guess = 16'sd1;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic rd(input int a, output logic signed [W-1:0] d);
    @(negedge clk);
    rd_addr = AW'(a);
    @(posedge clk); #1;
    d = rd_data;
  endtask

  task automatic load_std();
    for (int i = 0; i < N; i++) wr(i, 100 * (i + 1), 5);
  endtask

  // Runs 200 edges after the start edge; optional injected write/start
  task automatic run_batch(input int wr_at, input int st_at,
                           output int done_cyc, output int ndone,
                           output int nload, output logic b0,
                           output logic l0);
    done_cyc = -1; ndone = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    b0 = busy; l0 = div_load;
    nload = div_load ? 1 : 0;
    for (int k = 1; k < 200; k++) begin
      @(negedge clk);
      if (k == wr_at) begin
        wr_en = 1'b1; wr_addr = '0;
        wr_nr = 16'sd999; wr_dr = 16'sd1;
      end
      start = (k == st_at);
      @(posedge clk); #1;
      wr_en = 1'b0; start = 1'b0;
      if (div_load) nload++;
      if (done) begin ndone++; done_cyc = k + 1; end
    end
  endtask

  task automatic chk_std_results(input string tag);
    logic signed [W-1:0] d;
    for (int i = 0; i < N; i++) begin
      rd(i, d);
      total++;
      if (d !== W'(20 * (i + 1))) begin
        bad++;
        $display("FAIL %s res[%0d]: got %0d want %0d",
                 tag, i, d, 20 * (i + 1));
      end
    end
  endtask

  task automatic test_reset();
    logic signed [W-1:0] d;
    rst = 1'b1;
    #1;
    total++;
    if ({busy, done, div_load, dz_mask, div_nr, div_dr, div_guess,
         rd_data} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: busy=%b done=%b load=%b dz=%b",
               busy, done, div_load, dz_mask);
    end
    #30;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rd(i, d);
      total++;
      if (d !== '0) begin
        bad++;
        $display("FAIL reset_rd[%0d]: got %0d want 0", i, d);
      end
    end
  endtask

  task automatic test_full_batch();
    int dc, nd, nl;
    logic b0, l0;
    load_std();
    run_batch(-1, -1, dc, nd, nl, b0, l0);
    total++;
    if ({b0, l0} !== 2'b11) begin
      bad++;
      $display("FAIL full_first: busy=%b load=%b want 1 1", b0, l0);
    end
    total++;
    if (dc !== 163 || nd !== 1) begin
      bad++;
      $display("FAIL full_done: cyc=%0d n=%0d want 163 1", dc, nd);
    end
    total++;
    if (nl !== 9) begin
      bad++;
      $display("FAIL full_loads: got %0d want 9", nl);
    end
    total++;
    if (dz_mask !== 9'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL full_dz: dz=%b busy=%b want 0 0", dz_mask, busy);
    end
    chk_std_results("full");
  endtask

  task automatic test_zero_div();
    int dc, nd, nl;
    logic b0, l0;
    logic signed [W-1:0] d;
    wr(3, 50, 0);
    wr(4, -7, 0);
    run_batch(-1, -1, dc, nd, nl, b0, l0);
    total++;
    if (dc !== 129) begin
      bad++;
      $display("FAIL dz_done: cyc=%0d want 129", dc);
    end
    total++;
    if (nl !== 7) begin
      bad++;
      $display("FAIL dz_loads: got %0d want 7", nl);
    end
    total++;
    if (dz_mask !== 9'b000011000) begin
      bad++;
      $display("FAIL dz_mask: got %b want 000011000", dz_mask);
    end
    rd(3, d);
    total++;
    if (d !== 16'sh7FFF) begin
      bad++;
      $display("FAIL dz_res3: got %h want 7fff", d);
    end
    rd(4, d);
    total++;
    if (d !== 16'sh8001) begin
      bad++;
      $display("FAIL dz_res4: got %h want 8001", d);
    end
    rd(5, d);
    total++;
    if (d !== 16'sd120) begin
      bad++;
      $display("FAIL dz_res5: got %0d want 120", d);
    end
  endtask

  task automatic test_illegal();
    int dc, nd, nl;
    logic b0, l0;
    wr(3, 400, 5);
    wr(4, 500, 5);
    run_batch(50, 60, dc, nd, nl, b0, l0);
    total++;
    if (nd !== 1 || dc !== 163) begin
      bad++;
      $display("FAIL illegal_done: n=%0d cyc=%0d want 1 163", nd, dc);
    end
    chk_std_results("illegal");
  endtask

  task automatic test_reset_mid();
    int dc, nd, nl;
    logic b0, l0;
    logic signed [W-1:0] d;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (39) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || div_load !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_async: busy=%b load=%b want 0 0",
               busy, div_load);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      rd(i, d);
      total++;
      if (d !== '0) begin
        bad++;
        $display("FAIL rstmid_res[%0d]: got %0d want 0", i, d);
      end
    end
    load_std();
    run_batch(-1, -1, dc, nd, nl, b0, l0);
    total++;
    if (dc !== 163 || nd !== 1) begin
      bad++;
      $display("FAIL rstmid_done: cyc=%0d n=%0d want 163 1", dc, nd);
    end
    chk_std_results("rstmid");
  endtask

  task automatic test_out_of_range();
    int dc, nd, nl;
    logic b0, l0;
    logic signed [W-1:0] d;
    rd(9, d);
    total++;
    if (d !== '0) begin
      bad++;
      $display("FAIL oor_rd9: got %0d want 0", d);
    end
    rd(15, d);
    total++;
    if (d !== '0) begin
      bad++;
      $display("FAIL oor_rd15: got %0d want 0", d);
    end
    wr(12, 1, 0);
    run_batch(-1, -1, dc, nd, nl, b0, l0);
    total++;
    if (dc !== 163 || dz_mask !== 9'b0) begin
      bad++;
      $display("FAIL oor_batch: cyc=%0d dz=%b want 163 0", dc, dz_mask);
    end
    chk_std_results("oor");
  endtask

  task automatic test_write_with_start();
    int dc, nd, nl;
    logic b0, l0;
    logic signed [W-1:0] d;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = '0;
    wr_nr = 16'sd77; wr_dr = 16'sd7; wr_guess = 16'sd1;
    start = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0; start = 1'b0;
    total++;
    if (div_nr !== 16'sd77 || div_dr !== 16'sd7) begin
      bad++;
      $display("FAIL wrstart_ops: nr=%0d dr=%0d want 77 7",
               div_nr, div_dr);
    end
    repeat (170) @(posedge clk);
    #1;
    rd(0, d);
    total++;
    if (d !== 16'sd11) begin
      bad++;
      $display("FAIL wrstart_res0: got %0d want 11", d);
    end
  endtask

  initial begin
    test_reset();
    test_full_batch();
    test_zero_div();
    test_illegal();
    test_reset_mid();
    test_out_of_range();
    test_write_with_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
